// File: rtl/sync_fifo_wr_arbiter.sv
// rtl/sync_fifo_wr_arbiter.sv - round-robin burst-locked write-port arbiter in front of sync_fifo
//
// Purpose:
//   Shares one sync_fifo write interface among NUM_REQ valid/ready sources.
//   A grantee keeps the port until it marks a last beat or has moved
//   MAX_BURST beats, so bursts from different sources never interleave.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_valid/i_data/i_last/o_ready   per-requester beat handshake
//                                   (requester k data at [k*DATA_WIDTH +: DATA_WIDTH])
//   o_valid_s/o_datain              write request/data to the FIFO
//   i_ready_s/i_almostfull          FIFO not-full and almost-full status
//   o_grant_id                      current or most recent grantee
//   o_busy                          a grant is active
//
// Optional feature:
//   SYNC_FIFO_ARB_AFULL_GATE_EN - when defined, no new grant is issued while
//   i_almostfull is high; an active grant is never cut short.
module sync_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_last,
  output logic [NUM_REQ-1:0]            o_ready,
  output logic                          o_valid_s,
  output logic [DATA_WIDTH-1:0]         o_datain,
  input  logic                          i_ready_s,
  input  logic                          i_almostfull,
  output logic [ID_WIDTH-1:0]           o_grant_id,
  output logic                          o_busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;

  logic [ID_WIDTH-1:0] win_id;
  logic [ID_WIDTH-1:0] cand;
  logic                win_found;
  logic                gate_open;
  logic                lock;
  logic                xfer;

`ifdef SYNC_FIFO_ARB_AFULL_GATE_EN
  assign gate_open = ~i_almostfull;
`else
  // Port kept for a uniform footprint; it has no effect in this build.
  logic unused_almostfull;
  assign unused_almostfull = i_almostfull;
  assign gate_open = 1'b1;
`endif

  assign lock    = (state_q == ST_LOCK);
  assign cnt_inc = cnt_q + 1'b1;

  // Reset forces the master side quiet so nothing lands in the FIFO
  // during the cycle that aborts a burst.
  assign o_valid_s = lock & i_valid[grant_q] & ~i_rst;
  assign xfer      = o_valid_s & i_ready_s;

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_ready[k] = lock & (grant_q == ID_WIDTH'(k)) & i_ready_s & ~i_rst;
    end
  end

  always_comb begin
    o_datain = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q == ID_WIDTH'(k)) begin
        o_datain = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin search: first valid requester at ptr+1, ptr+2, ... with wrap;
  // ptr itself is visited last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && i_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found && gate_open) begin
          state_d = ST_LOCK;
          grant_d = win_id;
          ptr_d   = win_id;
          cnt_d   = '0;
        end
      end
      ST_LOCK: begin
        // A stalled or silent grantee simply holds the port; only a
        // transferring beat can end the burst.
        if (xfer) begin
          cnt_d = cnt_inc;
          if (i_last[grant_q] || (cnt_inc == CNT_W'(MAX_BURST))) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant_id = grant_q;
  assign o_busy     = lock;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb/tb_sync_fifo_wr_arbiter.sv - self-checking bench for sync_fifo_wr_arbiter
module tb_sync_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          i_clk;
  logic          i_rst;
  logic [N-1:0]  i_valid;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]  i_last;
  logic [N-1:0]  o_ready;
  logic          o_valid_s;
  logic [DW-1:0] o_datain;
  logic          i_ready_s;
  logic          i_almostfull;
  logic [1:0]    o_grant_id;
  logic          o_busy;

  sync_fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_valid_s   (o_valid_s),
    .o_datain    (o_datain),
    .i_ready_s   (i_ready_s),
    .i_almostfull(i_almostfull),
    .o_grant_id  (o_grant_id),
    .o_busy      (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-requester source queues: {last, data}
  logic [8:0] mem [N][256];
  int hd[N];
  int tl[N];
  int sq[N];

  // FIFO write log
  int         n_wr;
  int         wr_src [4096];
  logic [7:0] wr_dat [4096];
  int         wr_cyc [4096];

  // Stimulus knobs
  int p_valid;
  int p_ready;
  int af_mode;   // 0 random, 1 force high, 2 force low
  bit rst_drv;
  int cyc;

  // Reference model: owner of the port (-1 none), last grantee, rr pointer, beats in burst
  int m_owner;
  int m_gid;
  int m_ptr;
  int m_cnt;

  task automatic push(input int k, input bit last, input logic [7:0] d);
    mem[k][tl[k] % 256] = {last, d};
    tl[k]++;
  endtask

  task automatic clear_q();
    for (int k = 0; k < N; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end
    n_wr = 0;
  endtask

  task automatic step();
    logic [8:0] e;
    bit         exp_valid;
    bit         gate;
    logic [3:0] exp_ready;
    int         kk;
    for (int k = 0; k < N; k++) begin
      e = mem[k][hd[k] % 256];
      i_valid[k] = (hd[k] < tl[k]) && ($urandom_range(99) < p_valid);
      i_last[k]  = e[8];
      i_data[k*DW +: DW] = (hd[k] < tl[k]) ? e[7:0] : 8'($urandom);
    end
    i_ready_s    = ($urandom_range(99) < p_ready);
    i_almostfull = (af_mode == 0) ? 1'($urandom_range(1)) : (af_mode == 1);
    i_rst        = rst_drv;
    #1;
    exp_valid = !rst_drv && (m_owner >= 0) && i_valid[m_owner];
    exp_ready = (!rst_drv && (m_owner >= 0) && i_ready_s) ? 4'(1 << m_owner) : 4'd0;
    check_eq("busy", 32'(o_busy), 32'(m_owner >= 0));
    check_eq("grant_id", 32'(o_grant_id), 32'(m_gid));
    check_eq("valid_s", 32'(o_valid_s), 32'(exp_valid));
    check_eq("ready", 32'(o_ready), 32'(exp_ready));
    if (exp_valid) begin
      e = mem[m_owner][hd[m_owner] % 256];
      check_eq("datain", 32'(o_datain), 32'(e[7:0]));
    end
    if (o_valid_s && i_ready_s && n_wr < 4096) begin
      wr_src[n_wr] = int'(o_grant_id);
      wr_dat[n_wr] = o_datain;
      wr_cyc[n_wr] = cyc;
      n_wr++;
    end
    for (int k = 0; k < N; k++) begin
      if (i_valid[k] && o_ready[k]) hd[k]++;
    end
`ifdef SYNC_FIFO_ARB_AFULL_GATE_EN
    gate = !i_almostfull;
`else
    gate = 1'b1;
`endif
    if (rst_drv) begin
      m_owner = -1; m_gid = 0; m_ptr = N - 1; m_cnt = 0;
    end else if (m_owner < 0) begin
      if (gate) begin
        for (int i = 1; i <= N; i++) begin
          kk = (m_ptr + i) % N;
          if (m_owner < 0 && i_valid[kk]) begin
            m_owner = kk; m_gid = kk; m_ptr = kk; m_cnt = 0;
          end
        end
      end
    end else if (exp_valid && i_ready_s) begin
      m_cnt++;
      if (i_last[m_owner] || m_cnt == MB) m_owner = -1;
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
  endtask

  int c0;
  int blen;

  initial begin
    i_rst = 1'b1; i_valid = '0; i_data = '0; i_last = '0;
    i_ready_s = 1'b1; i_almostfull = 1'b0;
    p_valid = 100; p_ready = 100; af_mode = 2; rst_drv = 1'b0; cyc = 0;
    m_owner = -1; m_gid = 0; m_ptr = N - 1; m_cnt = 0;
    for (int k = 0; k < N; k++) sq[k] = 0;
    clear_q();
    @(posedge i_clk); #1;

    // Reset state
    do_reset();
    do_reset();
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_gid", 32'(o_grant_id), 0);
    check_eq("rst_ready", 32'(o_ready), 0);
    check_eq("rst_valid_s", 32'(o_valid_s), 0);

    // Single-source burst from requester 2
    push(2, 0, 8'hA1); push(2, 0, 8'hA2); push(2, 1, 8'hA3);
    c0 = cyc;
    for (int t = 0; t < 8; t++) step();
    check_eq("single_cnt", 32'(n_wr), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("single_data", 32'(wr_dat[i]), 32'(8'hA1 + i));
      check_eq("single_cyc", 32'(wr_cyc[i] - c0), 32'(1 + i));
    end
    check_eq("single_gid", 32'(o_grant_id), 2);
    check_eq("single_busy", 32'(o_busy), 0);

    // Round-robin fairness with single-beat bursts
    clear_q();
    do_reset();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 4; j++) push(k, 1, 8'((k << 4) | j));
    for (int t = 0; t < 20; t++) step();
    for (int i = 0; i < 8; i++) check_eq("rr_order", 32'(wr_src[i]), 32'(i % N));
    for (int i = 0; i < 7; i++) check_eq("rr_gap", 32'(wr_cyc[i+1] - wr_cyc[i]), 2);

    // Burst cap: requester 1 never marks last, requester 3 competes
    clear_q();
    do_reset();
    for (int j = 0; j < 6; j++) push(1, 0, 8'(8'h11 + j));
    push(3, 1, 8'h31);
    for (int t = 0; t < 12; t++) step();
    check_eq("cap_cnt", 32'(n_wr), 7);
    begin
      logic [7:0] exp_seq [7];
      exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h31, 8'h15, 8'h16};
      for (int i = 0; i < 7; i++) check_eq("cap_data", 32'(wr_dat[i]), 32'(exp_seq[i]));
    end
    check_eq("cap_bubble", 32'(wr_cyc[4] - wr_cyc[3]), 2);

    // FIFO backpressure mid-burst
    clear_q();
    do_reset();
    for (int j = 0; j < 4; j++) push(0, j == 3, 8'(8'hD1 + j));
    for (int t = 0; t < 10; t++) begin
      p_ready = (t >= 3 && t < 6) ? 0 : 100;
      step();
    end
    p_ready = 100;
    check_eq("bp_cnt", 32'(n_wr), 4);
    for (int i = 0; i < 4; i++) check_eq("bp_data", 32'(wr_dat[i]), 32'(8'hD1 + i));
    check_eq("bp_stall", 32'(wr_cyc[2] - wr_cyc[1]), 4);

    // Reset mid-burst
    clear_q();
    do_reset();
    for (int j = 0; j < 4; j++) push(2, j == 3, 8'(8'hE1 + j));
    for (int t = 0; t < 3; t++) step();
    check_eq("mid_beats", 32'(n_wr), 2);
    push(0, 1, 8'h01);
    push(1, 1, 8'h02);
    do_reset();
    check_eq("mid_rst_busy", 32'(o_busy), 0);
    check_eq("mid_rst_gid", 32'(o_grant_id), 0);
    n_wr = 0;
    for (int t = 0; t < 6; t++) step();
    check_eq("mid_first_src", 32'(wr_src[0]), 0);

    // Almost-full gate in IDLE
    clear_q();
    do_reset();
    push(0, 1, 8'h5A);
    af_mode = 1;
    step();
`ifdef SYNC_FIFO_ARB_AFULL_GATE_EN
    check_eq("afull_gate", 32'(o_busy), 0);
`else
    check_eq("afull_gate", 32'(o_busy), 1);
`endif
    for (int t = 0; t < 2; t++) step();
    af_mode = 2;
    for (int t = 0; t < 4; t++) step();
    check_eq("afull_done", 32'(n_wr), 1);

    // Randomized traffic
    clear_q();
    do_reset();
    af_mode = 0; p_valid = 70; p_ready = 70;
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < N; k++) begin
        if (tl[k] - hd[k] < 8) begin
          blen = int'($urandom_range(1, 6));
          for (int j = 0; j < blen; j++) begin
            push(k, (j == blen - 1) && ($urandom_range(3) != 0), 8'({k[1:0], sq[k][5:0]}));
            sq[k]++;
          end
        end
      end
      rst_drv = ($urandom_range(399) == 0);
      n_wr = 0;
      step();
    end
    rst_drv = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
